demux2w32_reg: RTL and testbench
================================

# demux2w32_reg

Registered 1-to-2 demultiplexer for 32-bit datapath words. It is the inverse of the 2:1 word multiplexer: one producer stream is steered to one of two consumer ports by a per-word select, with a valid/ready handshake on every port. It sits between a datapath result source and two destinations, such as the register-file write port and the memory store path. Each output holds its word until the consumer takes it, and a per-port transfer counter is kept for debug.

## Interface
Parameters:
- WIDTH, 32, data word width
- CNT_W, 16, width of each per-port transfer counter

Ports:
- clk  input  1  rising-edge clock; the block's only clock
- rst_n  input  1  synchronous, active-low reset
- in  input  WIDTH  input data word
- sel  input  1  destination of the word on `in`: 0 = port 1, 1 = port 2; part of the payload
- in_valid  input  1  producer offers in/sel
- in_ready  output  1  block accepts in/sel this cycle
- out1, out2  output  WIDTH  held data per port
- out1_valid, out2_valid  output  1  port holds an untaken word
- out1_ready, out2_ready  input  1  consumer takes the word this cycle
- cnt1, cnt2  output  CNT_W  completed output transfers per port

## Operation
- Each port is a one-deep slot with two states:
  - EMPTY: outN_valid=0.
  - FULL: outN_valid=1, outN stable.
- Transfer rules:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer on port N occurs when outN_valid & outN_ready.
- in_ready = (selected slot EMPTY) | (selected slot FULL & its outN_ready). in_ready is combinational from sel and the selected outN_ready. It never depends on in_valid.
- Slot transitions:
  - EMPTY → FULL on an input transfer to that slot.
  - FULL → EMPTY on an output transfer with no input transfer to that slot.
  - FULL → FULL, reloaded with the new word, on a simultaneous output and input transfer to that slot.
  - Otherwise the slot holds.
- The non-selected slot is unaffected by in, sel and in_valid. It drains independently through its own outN_ready.
- Ordering is preserved within a port. No ordering is defined across ports.
- outN is written only on an input transfer to slot N. In EMPTY it retains its last value and is don't-care to consumers.
- Producer rule: while in_valid=1 and in_ready=0, the producer holds in and sel stable. The bench asserts this. The block does not need to tolerate violations.
- cntN increments by 1 on each output transfer on port N. It wraps from 2^CNT_W−1 to 0.
- Reset mid-operation: all held words are dropped. In-flight handshakes in the reset cycle do not complete.

## Timing
- Reset values, in the cycle after rst_n is sampled low: out1=out2=0, out1_valid=out2_valid=0, cnt1=cnt2=0. in_ready=1 in the first cycle after reset.
- Latency: 1 cycle. A word accepted at edge k appears on outN with outN_valid=1 after edge k.
- Throughput: 1 word/cycle sustained to a single port while its consumer holds ready=1. 1 word/cycle is also sustained when alternating ports.
- Full-port back-pressure: with slot N FULL and outN_ready=0, a word for port N sees in_ready=0. If sel is changed to an EMPTY port instead, in_ready=1.
- No combinational path from in or in_valid to any output.

## Structure
- Shared package `demux_pkg`:
  - slot state enum {EMPTY, FULL}
  - default WIDTH and CNT_W constants
- Sub-module `demux_slot` (parameterised on WIDTH and CNT_W), instantiated twice:
  - Inputs: load, data, out_ready.
  - Outputs: out, out_valid, cnt, and can_load = !out_valid | out_ready.
- Top level: computes the per-slot load from sel, in_valid and in_ready. Muxes the two can_load signals by sel to form in_ready.

## Test plan
- Reset, then idle → all outputs 0, in_ready=1. Assert rst_n low mid-stream with both slots FULL → both valids 0 and both counters 0 on the next cycle.
- Stream 0x00000001..0x00000008 with sel=0 and out1_ready=1 held → out1 shows the same sequence, 1-cycle latency, no bubbles, cnt1=8, out2_valid never 1.
- Alternate sel 0/1 with words 0xA0000000+i and both readies=1 → each port receives its words in order, 1 word/cycle total.
- Send 0xDEADBEEF to port 2 with out2_ready=0, then offer 0x12345678 to port 2 → in_ready=0 and out2 stays 0xDEADBEEF. Switch the offer to port 1 → accepted next cycle. Raise out2_ready → the port 2 slot drains, cnt2=1.
- Slot 1 FULL; in the same cycle out1_ready=1 and a new word 0xCAFEF00D for port 1 → out1_valid stays 1, out1=0xCAFEF00D next cycle, cnt1 +1.
- With CNT_W=4, perform 17 transfers on port 1 → cnt1 reads 1 after the 17th transfer.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared types and default sizes for the registered 1-to-2 word demultiplexer.
package demux_pkg;

  localparam int unsigned DEMUX_WIDTH = 32;
  localparam int unsigned DEMUX_CNT_W = 16;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/demux_slot.sv
// One-deep output slot with valid/ready handshake and a wrapping transfer counter.
module demux_slot
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = DEMUX_WIDTH,
  parameter int unsigned CNT_W = DEMUX_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic [CNT_W-1:0] cnt,
  output logic             can_load
);

  slot_state_e      state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // State, held word and counter; reset drops any held word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: load wins over drain so a simultaneous take-and-refill stays FULL.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    if ((state_q == FULL) && out_ready) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    unique case (state_q)
      EMPTY: begin
        if (load) begin
          state_d = FULL;
          data_d  = data;
        end
      end
      FULL: begin
        if (load) begin
          data_d = data;
        end else if (out_ready) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  assign out       = data_q;
  assign out_valid = (state_q == FULL);
  assign cnt       = cnt_q;
  assign can_load  = (state_q == EMPTY) || out_ready;

endmodule

// File: rtl/demux2w32_reg.sv
// Registered 1-to-2 demultiplexer: steers each accepted word to the slot chosen by sel.
module demux2w32_reg
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = DEMUX_WIDTH,
  parameter int unsigned CNT_W = DEMUX_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic             sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic             out1_valid,
  output logic             out2_valid,
  input  logic             out1_ready,
  input  logic             out2_ready,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2
);

  logic can_load1, can_load2;
  logic in_xfer;
  logic load1, load2;

  // in_ready depends only on sel and the selected slot, never on in_valid.
  assign in_ready = sel ? can_load2 : can_load1;
  assign in_xfer  = in_valid && in_ready;
  assign load1    = in_xfer && !sel;
  assign load2    = in_xfer && sel;

  demux_slot #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_slot1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load1),
    .data     (in),
    .out_ready(out1_ready),
    .out      (out1),
    .out_valid(out1_valid),
    .cnt      (cnt1),
    .can_load (can_load1)
  );

  demux_slot #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_slot2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load2),
    .data     (in),
    .out_ready(out2_ready),
    .out      (out2),
    .out_valid(out2_valid),
    .cnt      (cnt2),
    .can_load (can_load2)
  );

endmodule

// File: tb/tb_demux2w32_reg.sv
// Self-checking bench for demux2w32_reg using a small slot model and per-port scoreboards.
module tb_demux2w32_reg;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] in_w;
  logic             sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out1, out2;
  logic             out1_valid, out2_valid;
  logic             out1_ready, out2_ready;
  logic [CNT_W-1:0] cnt1, cnt2;

  always #5 clk = ~clk;

  demux2w32_reg #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in        (in_w),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out1      (out1),
    .out2      (out2),
    .out1_valid(out1_valid),
    .out2_valid(out2_valid),
    .out1_ready(out1_ready),
    .out2_ready(out2_ready),
    .cnt1      (cnt1),
    .cnt2      (cnt2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic             m_full1 = 1'b0, m_full2 = 1'b0;
  logic [CNT_W-1:0] m_cnt1 = '0, m_cnt2 = '0;
  logic [WIDTH-1:0] q1[$];
  logic [WIDTH-1:0] q2[$];

  function automatic logic m_rdy();
    return sel ? (!m_full2 || out2_ready) : (!m_full1 || out1_ready);
  endfunction

  // Drive inputs just after the falling edge.
  task automatic drive(input logic r, input logic v, input logic s, input logic [WIDTH-1:0] d,
                       input logic r1, input logic r2);
    @(negedge clk);
    rst_n = r; in_valid = v; sel = s; in_w = d; out1_ready = r1; out2_ready = r2;
    #1;
  endtask

  // Advance the reference model across the coming rising edge.
  task automatic model_edge();
    logic acc, o1, o2;
    acc = in_valid && m_rdy();
    o1  = m_full1 && out1_ready;
    o2  = m_full2 && out2_ready;
    if (!rst_n) begin
      q1.delete(); q2.delete();
      m_cnt1 = '0; m_cnt2 = '0;
    end else begin
      if (o1) begin void'(q1.pop_front()); m_cnt1 = m_cnt1 + CNT_W'(1); end
      if (o2) begin void'(q2.pop_front()); m_cnt2 = m_cnt2 + CNT_W'(1); end
      if (acc && !sel) q1.push_back(in_w);
      if (acc && sel)  q2.push_back(in_w);
    end
    m_full1 = (q1.size() != 0);
    m_full2 = (q2.size() != 0);
    @(posedge clk);
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    model_edge();
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    model_edge();
  endtask

  task automatic test_reset();
    do_reset();
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready_sel0 got %b want 1", in_ready); end
    n_checks++; if ({out1_valid, out2_valid} !== 2'b00) begin n_fail++; $display("FAIL reset_valids got %b want 00", {out1_valid, out2_valid}); end
    n_checks++; if (out1 !== '0 || out2 !== '0) begin n_fail++; $display("FAIL reset_data got %h/%h want 0/0", out1, out2); end
    n_checks++; if (cnt1 !== '0 || cnt2 !== '0) begin n_fail++; $display("FAIL reset_cnt got %0d/%0d want 0/0", cnt1, cnt2); end
    model_edge();
    drive(1'b1, 1'b0, 1'b1, '0, 1'b0, 1'b0);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready_sel1 got %b want 1", in_ready); end
    model_edge();
  endtask

  task automatic test_stream();
    for (int i = 1; i <= 10; i++) begin
      if (i <= 8) drive(1'b1, 1'b1, 1'b0, WIDTH'(i), 1'b1, 1'b0);
      else        drive(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0);
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready cyc%0d got %b want 1", i, in_ready); end
      n_checks++; if (out2_valid !== 1'b0) begin n_fail++; $display("FAIL stream_out2_valid cyc%0d got %b want 0", i, out2_valid); end
      n_checks++; if (out1_valid !== m_full1) begin n_fail++; $display("FAIL stream_out1_valid cyc%0d got %b want %b", i, out1_valid, m_full1); end
      if (m_full1) begin
        n_checks++; if (out1 !== q1[0] || out1 !== WIDTH'(i - 1)) begin n_fail++; $display("FAIL stream_out1 cyc%0d got %h want %h", i, out1, q1[0]); end
      end
      model_edge();
    end
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    n_checks++; if (cnt1 !== 4'd8) begin n_fail++; $display("FAIL stream_cnt1 got %0d want 8", cnt1); end
    model_edge();
  endtask

  task automatic test_alternate();
    for (int i = 0; i < 10; i++) begin
      if (i < 8) drive(1'b1, 1'b1, i[0], 32'hA000_0000 + WIDTH'(i), 1'b1, 1'b1);
      else       drive(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b1);
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL alt_in_ready cyc%0d got %b want 1", i, in_ready); end
      n_checks++; if ({out1_valid, out2_valid} !== {m_full1, m_full2}) begin n_fail++; $display("FAIL alt_valids cyc%0d got %b want %b", i, {out1_valid, out2_valid}, {m_full1, m_full2}); end
      if (m_full1) begin
        n_checks++; if (out1 !== q1[0]) begin n_fail++; $display("FAIL alt_out1 cyc%0d got %h want %h", i, out1, q1[0]); end
      end
      if (m_full2) begin
        n_checks++; if (out2 !== q2[0]) begin n_fail++; $display("FAIL alt_out2 cyc%0d got %h want %h", i, out2, q2[0]); end
      end
      model_edge();
    end
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    n_checks++; if (cnt1 !== m_cnt1 || cnt2 !== m_cnt2) begin n_fail++; $display("FAIL alt_cnt got %0d/%0d want %0d/%0d", cnt1, cnt2, m_cnt1, m_cnt2); end
    model_edge();
  endtask

  task automatic test_backpressure();
    do_reset();
    drive(1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    model_edge();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b1, 32'h1234_5678, 1'b0, 1'b0);
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_full cyc%0d got %b want 0", i, in_ready); end
      n_checks++; if (out2_valid !== 1'b1 || out2 !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL bp_out2_hold cyc%0d got %b/%h want 1/deadbeef", i, out2_valid, out2); end
      model_edge();
    end
    drive(1'b1, 1'b0, 1'b1, 32'h1234_5678, 1'b0, 1'b0);
    model_edge();
    drive(1'b1, 1'b1, 1'b0, 32'h1234_5678, 1'b0, 1'b0);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_in_ready_other got %b want 1", in_ready); end
    model_edge();
    drive(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b1);
    n_checks++; if (out1_valid !== 1'b1 || out1 !== 32'h1234_5678) begin n_fail++; $display("FAIL bp_out1 got %b/%h want 1/12345678", out1_valid, out1); end
    model_edge();
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    n_checks++; if (out2_valid !== 1'b0 || out1_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain got %b%b want 00", out1_valid, out2_valid); end
    n_checks++; if (cnt2 !== 4'd1 || cnt2 !== m_cnt2) begin n_fail++; $display("FAIL bp_cnt2 got %0d want 1", cnt2); end
    model_edge();
  endtask

  task automatic test_reload();
    logic [CNT_W-1:0] c0;
    drive(1'b1, 1'b1, 1'b0, 32'h1111_1111, 1'b0, 1'b0);
    model_edge();
    c0 = m_cnt1;
    drive(1'b1, 1'b1, 1'b0, 32'hCAFE_F00D, 1'b1, 1'b0);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reload_in_ready got %b want 1", in_ready); end
    n_checks++; if (out1 !== 32'h1111_1111) begin n_fail++; $display("FAIL reload_old got %h want 11111111", out1); end
    model_edge();
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    n_checks++; if (out1_valid !== 1'b1 || out1 !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL reload_new got %b/%h want 1/cafef00d", out1_valid, out1); end
    n_checks++; if (cnt1 !== c0 + CNT_W'(1)) begin n_fail++; $display("FAIL reload_cnt1 got %0d want %0d", cnt1, c0 + CNT_W'(1)); end
    model_edge();
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 1'b1, 1'b0, 32'h5000_0000 + WIDTH'(i), 1'b1, 1'b0);
      model_edge();
    end
    drive(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    model_edge();
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    n_checks++; if (cnt1 !== 4'd1 || m_cnt1 !== 4'd1) begin n_fail++; $display("FAIL wrap_cnt1 got %0d want 1", cnt1); end
    model_edge();
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b1, 1'b0, 32'h0000_00AA, 1'b0, 1'b0);
    model_edge();
    drive(1'b1, 1'b1, 1'b1, 32'h0000_00BB, 1'b0, 1'b0);
    model_edge();
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    n_checks++; if ({out1_valid, out2_valid} !== 2'b11) begin n_fail++; $display("FAIL mid_both_full got %b want 11", {out1_valid, out2_valid}); end
    model_edge();
    drive(1'b0, 1'b1, 1'b0, 32'h0000_00CC, 1'b1, 1'b1);
    model_edge();
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    n_checks++; if ({out1_valid, out2_valid} !== 2'b00) begin n_fail++; $display("FAIL mid_valids got %b want 00", {out1_valid, out2_valid}); end
    n_checks++; if (cnt1 !== '0 || cnt2 !== '0) begin n_fail++; $display("FAIL mid_cnt got %0d/%0d want 0/0", cnt1, cnt2); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_in_ready got %b want 1", in_ready); end
    model_edge();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; sel = 1'b0; in_w = '0;
    out1_ready = 1'b0; out2_ready = 1'b0;
    test_reset();
    test_stream();
    test_alternate();
    test_backpressure();
    test_reload();
    test_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
